// File: rtl/prgrom_loader_pkg.sv
// Shared types and constants for the program ROM loader: FSM states, NOP word, default width.
package prgrom_loader_pkg;

    localparam int unsigned DefAddrW = 14;
    localparam logic [31:0] NopWord  = 32'h0000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StData,
        StWrite,
        StDone,
        StErr
    } state_e;

    // Download in flight: the CPU is held and fetches see NOPs.
    function automatic logic is_busy(input state_e s);
        return s inside {StHdr0, StHdr1, StData, StWrite};
    endfunction

endpackage

// File: rtl/prgrom_loader_bram.sv
// Simple dual-port program RAM: one synchronous read port, one write port, single clock.
module prgrom_loader_bram #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q;

    // Same-cycle read of the write address returns the old word.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q <= mem[rd_addr];
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/prgrom_loader.sv
// Instruction-fetch ROM responder with a byte-stream download FSM that rewrites program memory
// while holding the CPU in reset.
module prgrom_loader
    import prgrom_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned DEPTH   = 2 ** ADDR_W,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rom_read_addr,
    output logic [31:0]       Jpadr,
    input  logic              load_start,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              cpu_hold,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-1:0] words_written
);

    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] ww_q, ww_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       buf_q, buf_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic              err_q, err_d;
    logic              nop_q;
    logic              accept;
    logic              wr_en;
    logic [15:0]       hdr_cnt;
    logic [16:0]       ww_next;
    logic [31:0]       rd_data;

    assign byte_ready = state_q inside {StHdr0, StHdr1, StData};
    assign accept     = byte_valid & byte_ready;
    assign hdr_cnt    = {byte_data, cnt_q[7:0]};
    assign ww_next    = 17'(ww_q) + 17'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ww_d    = ww_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        idle_d  = '0;
        err_d   = err_q;
        wr_en   = 1'b0;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                state_d = StIdle;
                if (load_start) begin
                    state_d = StHdr0;
                    err_d   = 1'b0;
                    ww_d    = '0;
                    idx_d   = '0;
                end
            end
            StHdr0: begin
                if (accept) begin
                    cnt_d[7:0] = byte_data;
                    state_d    = StHdr1;
                end
            end
            StHdr1: begin
                if (accept) begin
                    cnt_d[15:8] = byte_data;
                    if (hdr_cnt == 16'd0 || 32'(hdr_cnt) > DEPTH) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    buf_d[{idx_q, 3'b000} +: 8] = byte_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                wr_en   = 1'b1;
                ww_d    = ww_q + ADDR_W'(1);
                state_d = (ww_next == {1'b0, cnt_q}) ? StDone : StData;
            end
            default: state_d = StIdle;
        endcase

        // Inter-byte watchdog while waiting on the stream.
        if (byte_ready && !accept) begin
            if (idle_q == IdleW'(TIMEOUT - 1)) begin
                state_d = StErr;
            end else begin
                idle_d = idle_q + IdleW'(1);
            end
        end

        if (state_d == StErr) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ww_q    <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            idle_q  <= '0;
            err_q   <= 1'b0;
            nop_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ww_q    <= ww_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            nop_q   <= is_busy(state_q);
        end
    end

    prgrom_loader_bram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_bram (
        .clock   (clock),
        .rd_addr (rom_read_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (ww_q),
        .wr_data (buf_q)
    );

    assign Jpadr         = nop_q ? NopWord : rd_data;
    assign load_busy     = is_busy(state_q);
    assign cpu_hold      = load_busy;
    assign load_done     = (state_q == StDone);
    assign load_err      = err_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_prgrom_loader.sv
// Bench for prgrom_loader: directed scenarios plus randomized downloads checked against a
// word-level memory model built from the byte stream.
module tb_prgrom_loader;

    localparam int unsigned AW = 6;
    localparam int unsigned DP = 64;
    localparam int unsigned TO = 40;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] rom_read_addr = '0;
    logic [31:0]   Jpadr;
    logic          load_start = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          cpu_hold;
    logic          load_busy;
    logic          load_done;
    logic          load_err;
    logic [AW-1:0] words_written;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    logic [31:0] mm [DP];
    bit          known [DP];
    logic [7:0]  stream [$];

    prgrom_loader #(
        .ADDR_W  (AW),
        .DEPTH   (DP),
        .TIMEOUT (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rom_read_addr (rom_read_addr),
        .Jpadr         (Jpadr),
        .load_start    (load_start),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .cpu_hold      (cpu_hold),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .load_err      (load_err),
        .words_written (words_written)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (load_done === 1'b1) done_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit b2b);
        int n;
        if (!b2b) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (byte_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("byte_ready", 32'(byte_ready), 32'd1);
        @(negedge clock);
        if (!b2b) byte_valid = 1'b0;
    endtask

    task automatic send_range(input int from, input int to, input bit b2b);
        for (int i = from; i < to; i++) send_byte(stream[i], b2b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (load_busy !== 1'b0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("wait_idle", 32'(load_busy), 32'd0);
    endtask

    task automatic read_word(input logic [AW-1:0] a, output logic [31:0] d);
        rom_read_addr = a;
        @(negedge clock);
        d = Jpadr;
    endtask

    task automatic check_mem(input string tag, input int a);
        logic [31:0] d;
        if (known[a]) begin
            read_word(AW'(a), d);
            check(tag, d, mm[a]);
        end
    endtask

    // Memory effect of the first n_sent stream bytes: whole words only, from address 0.
    function automatic void apply_model(input int n_sent);
        int count;
        int nw;
        count = int'({stream[1], stream[0]});
        if (count == 0 || count > int'(DP)) return;
        nw = (n_sent - 2) / 4;
        if (nw > count) nw = count;
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < 4; k++) mm[w][8*k +: 8] = stream[2 + 4*w + k];
            known[w] = 1'b1;
        end
    endfunction

    function automatic void build_stream(input int count);
        stream.delete();
        stream.push_back(8'(count));
        stream.push_back(8'(count >> 8));
        for (int i = 0; i < 4 * count; i++) stream.push_back(8'($urandom));
    endfunction

    initial begin
        int d0;
        int count;
        bit b2b;
        logic [31:0] d;

        repeat (3) @(negedge clock);
        check("rst_jpadr", Jpadr, 32'h0);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_busy", 32'(load_busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_ww", 32'(words_written), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Two-word directed download
        stream = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        d0 = done_seen;
        pulse_start();
        check("t2_hold_on", 32'(cpu_hold), 32'd1);
        send_range(0, 10, 1'b0);
        wait_idle();
        check("t2_hold_off", 32'(cpu_hold), 32'd0);
        check("t2_ww", 32'(words_written), 32'd2);
        @(negedge clock);
        check("t2_done_once", 32'(done_seen - d0), 32'd1);
        apply_model(10);
        read_word(0, d);
        check("t2_mem0", d, 32'h1234_5678);
        read_word(1, d);
        check("t2_mem1", d, 32'hDEAD_BEEF);

        // Zero-count header
        stream = {8'h00, 8'h00};
        d0 = done_seen;
        pulse_start();
        send_range(0, 2, 1'b0);
        check("t3_err", 32'(load_err), 32'd1);
        check("t3_hold", 32'(cpu_hold), 32'd0);
        check("t3_ww", 32'(words_written), 32'd0);
        check("t3_no_done", 32'(done_seen - d0), 32'd0);
        check_mem("t3_mem0", 0);

        // Oversized header
        stream = {8'(DP + 1), 8'h00};
        pulse_start();
        send_range(0, 2, 1'b0);
        check("t3_big_err", 32'(load_err), 32'd1);

        // New load_start clears the error; load word 5 with a known value
        build_stream(6);
        stream[22] = 8'h05;
        stream[23] = 8'h00;
        stream[24] = 8'h01;
        stream[25] = 8'h20;
        pulse_start();
        check("t3_err_clear", 32'(load_err), 32'd0);
        send_range(0, 26, 1'b0);
        wait_idle();
        check("t1_ww", 32'(words_written), 32'd6);
        apply_model(26);

        // Memory survives reset; fetch latency of one edge
        reset = 1'b1;
        @(negedge clock);
        check("t1_rst_jpadr", Jpadr, 32'h0);
        reset = 1'b0;
        read_word(5, d);
        check("t1_mem5", d, 32'h2001_0005);

        // Randomized downloads
        for (int it = 0; it < 3; it++) begin
            count = $urandom_range(1, 12);
            b2b = 1'($urandom_range(0, 1));
            build_stream(count);
            d0 = done_seen;
            pulse_start();
            send_range(0, stream.size(), b2b);
            byte_valid = 1'b0;
            wait_idle();
            check("rnd_ww", 32'(words_written), 32'(count % DP));
            @(negedge clock);
            check("rnd_done_once", 32'(done_seen - d0), 32'd1);
            apply_model(stream.size());
            for (int a = 0; a <= count; a++) check_mem("rnd_mem", a);
        end

        // Full-depth download wraps words_written to zero
        build_stream(DP);
        d0 = done_seen;
        pulse_start();
        send_range(0, stream.size(), 1'b1);
        byte_valid = 1'b0;
        wait_idle();
        check("full_ww", 32'(words_written), 32'd0);
        @(negedge clock);
        check("full_done_once", 32'(done_seen - d0), 32'd1);
        apply_model(stream.size());
        for (int a = 0; a < int'(DP); a++) check_mem("full_mem", a);

        // Stall mid-stream until the watchdog fires
        build_stream(3);
        pulse_start();
        send_range(0, 7, 1'b0);
        repeat (TO - 2) @(negedge clock);
        check("t4_no_err_yet", 32'(load_err), 32'd0);
        for (int n = 0; n < 10 && load_err !== 1'b1; n++) @(negedge clock);
        check("t4_err", 32'(load_err), 32'd1);
        check("t4_hold", 32'(cpu_hold), 32'd0);
        check("t4_ww", 32'(words_written), 32'd1);
        apply_model(7);
        check_mem("t4_mem0", 0);
        check_mem("t4_mem1", 1);

        // Fetch during load, back-to-back valid through WRITE, load_start ignored while busy
        build_stream(2);
        d0 = done_seen;
        pulse_start();
        rom_read_addr = '0;
        send_range(0, 2, 1'b1);
        check("t5_nop", Jpadr, 32'h0);
        send_range(2, 6, 1'b1);
        check("t5_ready_write", 32'(byte_ready), 32'd0);
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
        send_range(6, 10, 1'b1);
        byte_valid = 1'b0;
        wait_idle();
        check("t5_ww", 32'(words_written), 32'd2);
        @(negedge clock);
        check("t5_done_once", 32'(done_seen - d0), 32'd1);
        apply_model(10);
        check_mem("t5_mem0", 0);
        check_mem("t5_mem1", 1);

        // Reset in the middle of DATA
        build_stream(4);
        d0 = done_seen;
        pulse_start();
        send_range(0, 8, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("t6_busy", 32'(load_busy), 32'd0);
        check("t6_hold", 32'(cpu_hold), 32'd0);
        check("t6_done", 32'(load_done), 32'd0);
        check("t6_err", 32'(load_err), 32'd0);
        check("t6_ready", 32'(byte_ready), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("t6_no_pulse", 32'(done_seen - d0), 32'd0);
        apply_model(8);
        check_mem("t6_mem0", 0);
        check_mem("t6_mem1", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
